tnn_neuron_sequencer: RTL

- Time-multiplexes one shared combinational 5-operand, 3-bit approximate TNN neuron core across NUM_NEURONS logical neurons of a hidden layer.
- Accepts one feature vector (NUM_FEAT features, 3 bits each) per inference.
- For each neuron, selects five features using a per-neuron configuration table and drives them to the core. Captures the core's 1-bit decision and returns the full bit vector through a valid/ready output.

---
 rtl/tnn_neuron_sequencer_if.sv | 48 ++++
 rtl/tnn_neuron_sequencer.sv | 125 ++++++++++++
 2 files changed

// File: rtl/tnn_neuron_sequencer_if.sv
// Bundle of the sequencer's configuration, input-vector, shared-core and
// result handshake signals.
//   slave  : sequencer side (consumes cfg/in_*/core_out/out_ready)
//   master : environment side (drives cfg/in_*/core_out/out_ready)
// Signals:
//   cfg_we/cfg_neuron/cfg_slot/cfg_idx : config table write port
//   in_valid/in_ready/in_feat           : feature vector handshake
//   core_a..core_e/core_out             : shared neuron core operands/decision
//   out_valid/out_ready/out_bits        : result handshake
//   busy                                : inference in progress or result pending
interface tnn_neuron_sequencer_if #(
    parameter int unsigned NUM_FEAT    = 11,
    parameter int unsigned NUM_NEURONS = 8,
    parameter int unsigned IDX_W       = 4,
    parameter int unsigned NRN_W       = 3
);
    logic                     cfg_we;
    logic [NRN_W-1:0]         cfg_neuron;
    logic [2:0]               cfg_slot;
    logic [IDX_W-1:0]         cfg_idx;
    logic                     in_valid;
    logic                     in_ready;
    logic [3*NUM_FEAT-1:0]    in_feat;
    logic [2:0]               core_a;
    logic [2:0]               core_b;
    logic [2:0]               core_c;
    logic [2:0]               core_d;
    logic [2:0]               core_e;
    logic                     core_out;
    logic                     out_valid;
    logic                     out_ready;
    logic [NUM_NEURONS-1:0]   out_bits;
    logic                     busy;

    modport slave (
        input  cfg_we, cfg_neuron, cfg_slot, cfg_idx,
        input  in_valid, in_feat, core_out, out_ready,
        output in_ready, core_a, core_b, core_c, core_d, core_e,
        output out_valid, out_bits, busy
    );

    modport master (
        output cfg_we, cfg_neuron, cfg_slot, cfg_idx,
        output in_valid, in_feat, core_out, out_ready,
        input  in_ready, core_a, core_b, core_c, core_d, core_e,
        input  out_valid, out_bits, busy
    );
endinterface

// File: rtl/tnn_neuron_sequencer.sv
// Time-multiplexes one shared 5-operand, 3-bit TNN neuron core across
// NUM_NEURONS logical neurons. A latched feature vector is walked neuron by
// neuron; each neuron's five operands are picked from the vector through a
// per-neuron index table, and the core's decisions are collected into
// out_bits, returned through a valid/ready handshake.
// Ports:
//   clk  : rising-edge clock
//   rst  : asynchronous active-high reset
//   bus  : tnn_neuron_sequencer_if.slave (config, input, core, output, busy)
module tnn_neuron_sequencer #(
    parameter int unsigned NUM_FEAT    = 11,
    parameter int unsigned NUM_NEURONS = 8,
    parameter int unsigned IDX_W       = 4,
    parameter int unsigned NRN_W       = 3
) (
    input  logic                  clk,
    input  logic                  rst,
    tnn_neuron_sequencer_if.slave bus
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t                 state;
    state_t                 next_state;
    logic [NRN_W-1:0]       ptr;
    logic [2:0]             feat [NUM_FEAT];
    logic [IDX_W-1:0]       cfg  [NUM_NEURONS][5];
    logic [NUM_NEURONS-1:0] bits_q;
    logic [2:0]             op   [5];
    logic                   last_ptr;
    logic                   cfg_ok;

    assign last_ptr = (ptr == NRN_W'(NUM_NEURONS - 1));

    // Table writes are blocked in RUN so an inference sees one consistent table.
    assign cfg_ok = bus.cfg_we && (state != RUN)
                 && (32'(bus.cfg_slot) < 5)
                 && (32'(bus.cfg_neuron) < NUM_NEURONS);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= next_state;
        end
    end

    always_comb begin
        next_state = state;
        case (state)
            IDLE:    if (bus.in_valid)  next_state = RUN;
            RUN:     if (last_ptr)      next_state = DONE;
            DONE:    if (bus.out_ready) next_state = IDLE;
            default: next_state = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            ptr    <= '0;
            bits_q <= '0;
            for (int unsigned k = 0; k < NUM_FEAT; k++) begin
                feat[k] <= '0;
            end
            for (int unsigned n = 0; n < NUM_NEURONS; n++) begin
                for (int unsigned s = 0; s < 5; s++) begin
                    cfg[n][s] <= '0;
                end
            end
        end else begin
            if (state == IDLE && bus.in_valid) begin
                for (int unsigned k = 0; k < NUM_FEAT; k++) begin
                    feat[k] <= bus.in_feat[3*k +: 3];
                end
                ptr <= '0;
            end
            if (state == RUN) begin
                bits_q[ptr] <= bus.core_out;
                if (!last_ptr) begin
                    ptr <= ptr + NRN_W'(1);
                end
            end
            if (cfg_ok) begin
                for (int unsigned n = 0; n < NUM_NEURONS; n++) begin
                    for (int unsigned s = 0; s < 5; s++) begin
                        if (bus.cfg_neuron == NRN_W'(n) && bus.cfg_slot == 3'(s)) begin
                            cfg[n][s] <= bus.cfg_idx;
                        end
                    end
                end
            end
        end
    end

    // Operand mux: an index that matches no feature selects value 0, which
    // also covers stored indices >= NUM_FEAT. Operands are forced to 0
    // outside RUN so the core stays quiet.
    always_comb begin
        for (int unsigned s = 0; s < 5; s++) begin
            op[s] = '0;
            if (state == RUN) begin
                for (int unsigned k = 0; k < NUM_FEAT; k++) begin
                    if (cfg[ptr][s] == IDX_W'(k)) begin
                        op[s] = feat[k];
                    end
                end
            end
        end
    end

    assign bus.core_a    = op[0];
    assign bus.core_b    = op[1];
    assign bus.core_c    = op[2];
    assign bus.core_d    = op[3];
    assign bus.core_e    = op[4];
    assign bus.in_ready  = (state == IDLE);
    assign bus.out_valid = (state == DONE);
    assign bus.busy      = (state != IDLE);
    assign bus.out_bits  = bits_q;

endmodule
